// File: rtl/sw_input_conditioner.sv
// Switch input stage: synchronizes and debounces two raw switches, generates the
// slow demo clock and presents a stable sampled pair once per slow period.
module sw_input_conditioner #(
  parameter int TICK_COUNT      = 20000000,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_w_raw,
  input  logic sw_x_raw,
  output logic w_db,
  output logic x_db,
  output logic w_edge,
  output logic x_edge,
  output logic tick,
  output logic clk_slow,
  output logic w_smp,
  output logic x_smp,
  output logic smp_valid
);

  localparam logic [31:0] DB_LAST   = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] TICK_LAST = 32'(TICK_COUNT - 1);

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  logic [SYNC_STAGES-1:0] sync_w_p0;
  logic [SYNC_STAGES-1:0] sync_x_p0;
  logic [1:0]             raw_s;
  logic [1:0]             db_q;
  logic [1:0]             edge_q;
  logic [31:0]            db_cnt [2];
  logic [31:0]            tick_cnt;
  phase_t                 phase_q;
  phase_t                 phase_d;
  logic                   capture;

  // Stage 0: synchronizer chains, only the last flop is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_w_p0 <= '0;
      sync_x_p0 <= '0;
    end else begin
      sync_w_p0 <= {sync_w_p0[SYNC_STAGES-2:0], sw_w_raw};
      sync_x_p0 <= {sync_x_p0[SYNC_STAGES-2:0], sw_x_raw};
    end
  end

  assign raw_s = {sync_x_p0[SYNC_STAGES-1], sync_w_p0[SYNC_STAGES-1]};

  // Stage 1: per-channel debouncer; any return to the held level restarts the count
  for (genvar i = 0; i < 2; i++) begin : g_db
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt[i] <= '0;
        db_q[i]   <= 1'b0;
        edge_q[i] <= 1'b0;
      end else begin
        edge_q[i] <= 1'b0;
        if (raw_s[i] == db_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_q[i]   <= raw_s[i];
          edge_q[i] <= 1'b1;
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign w_db   = db_q[0];
  assign x_db   = db_q[1];
  assign w_edge = edge_q[0];
  assign x_edge = edge_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 32'd1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Stage 2: sampler; the phase register is the slow clock itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_LOW;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    capture = 1'b0;
    case (phase_q)
      PH_LOW: begin
        if (tick) begin
          capture = 1'b1;
          phase_d = PH_HIGH;
        end
      end
      PH_HIGH: begin
        if (tick) phase_d = PH_LOW;
      end
      default: phase_d = PH_LOW;
    endcase
  end

  assign clk_slow = (phase_q == PH_HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_smp     <= 1'b0;
      x_smp     <= 1'b0;
      smp_valid <= 1'b0;
    end else begin
      smp_valid <= capture;
      if (capture) begin
        w_smp <= w_db;
        x_smp <= x_db;
      end
    end
  end

endmodule
